// File: rtl/garage_motor_driver_if.sv
// Command and drive bundle between the door controller and the H-bridge motor driver.
// The controller (master) issues commands and fault inputs; the driver (slave) returns leg drives and status.
interface garage_motor_driver_if #(
  parameter int PWM_BITS = 8
) ();
  logic                up_m;
  logic                dn_m;
  logic                oc_fault;
  logic                fault_clr;
  logic                pwm_up;
  logic                pwm_dn;
  logic [PWM_BITS-1:0] duty;
  logic                busy;
  logic                fault;

  modport master (
    output up_m, dn_m, oc_fault, fault_clr,
    input  pwm_up, pwm_dn, duty, busy, fault
  );

  modport slave (
    input  up_m, dn_m, oc_fault, fault_clr,
    output pwm_up, pwm_dn, duty, busy, fault
  );
endinterface

// File: rtl/garage_motor_driver.sv
// H-bridge PWM driver with soft-start ramp, dead time on stop/reversal and filtered over-current trip.
// Build option: define MOTOR_SOFT_START_EN to enable the duty ramp; otherwise motion starts at full duty.
module garage_motor_driver #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_STEP   = 4,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  garage_motor_driver_if.slave   bus
);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS+1)'(RAMP_STEP);
  localparam int                  DW        = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_RUN, S_DEAD, S_FAULT} state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic                oc_q, oc_d;
  logic                pwm_up_q, pwm_up_d;
  logic                pwm_dn_q, pwm_dn_d;

  logic                cmd_valid;
  logic                cmd_dir;
  logic                pend;
  logic                trip;
  logic                drive;
  logic [PWM_BITS:0]   ramp_sum;

  assign cmd_valid = bus.up_m ^ bus.dn_m;
  assign cmd_dir   = bus.dn_m;
  assign pend      = (pcnt_q == DUTY_MAX);
  assign trip      = bus.oc_fault & oc_q;
  assign ramp_sum  = {1'b0, duty_q} + STEP;
  assign drive     = (state_q == S_RAMP || state_q == S_RUN) && (pcnt_q < duty_q);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    pcnt_d   = pcnt_q + PWM_BITS'(1);
    oc_d     = bus.oc_fault;
    pwm_up_d = drive && !dir_q;
    pwm_dn_d = drive && dir_q;

    // The over-current trip outranks every command or ramp event on the same edge.
    if (trip) begin
      state_d = S_FAULT;
      duty_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dir_d = cmd_dir;
`ifdef MOTOR_SOFT_START_EN
            state_d = S_RAMP;
`else
            state_d = S_RUN;
            duty_d  = DUTY_MAX;
`endif
          end
        end
        S_RAMP: begin
          if (!cmd_valid || cmd_dir != dir_q) begin
            state_d = S_DEAD;
            duty_d  = '0;
            dead_d  = DEAD_LOAD;
          end else if (pend) begin
            if (ramp_sum >= {1'b0, DUTY_MAX}) begin
              duty_d  = DUTY_MAX;
              state_d = S_RUN;
            end else begin
              duty_d  = ramp_sum[PWM_BITS-1:0];
            end
          end
        end
        S_RUN: begin
          if (!cmd_valid || cmd_dir != dir_q) begin
            state_d = S_DEAD;
            duty_d  = '0;
            dead_d  = DEAD_LOAD;
          end
        end
        S_DEAD: begin
          if (dead_q == '0) state_d = S_IDLE;
          else              dead_d  = dead_q - DW'(1);
        end
        S_FAULT: begin
          if (bus.fault_clr && !bus.oc_fault) begin
            state_d = S_DEAD;
            duty_d  = '0;
            dead_d  = DEAD_LOAD;
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      pcnt_q   <= '0;
      duty_q   <= '0;
      dead_q   <= '0;
      oc_q     <= 1'b0;
      pwm_up_q <= 1'b0;
      pwm_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pcnt_q   <= pcnt_d;
      duty_q   <= duty_d;
      dead_q   <= dead_d;
      oc_q     <= oc_d;
      pwm_up_q <= pwm_up_d;
      pwm_dn_q <= pwm_dn_d;
    end
  end

  assign bus.pwm_up = pwm_up_q;
  assign bus.pwm_dn = pwm_dn_q;
  assign bus.duty   = duty_q;
  assign bus.busy   = (state_q == S_RAMP) || (state_q == S_RUN) || (state_q == S_DEAD);
  assign bus.fault  = (state_q == S_FAULT);
endmodule
